// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline register family
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} skid_state_t;
  localparam int PIPE_W = 32;
endpackage

// File: rtl/regn_en.sv
// regn_en: n-bit register with load enable and async active-high reset to zero
module regn_en #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline register with registered in_ready
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int n = PIPE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic [1:0]   occ
);
  skid_state_t state, state_nx;
  logic in_fire, out_fire, main_en, skid_en;
  logic [n-1:0] main_d, skid_q;
  assign out_valid = state != EMPTY;
  assign in_ready  = state != FULL;
  assign occ       = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_nx;
  always_comb begin
    main_en = (state == EMPTY && in_fire) || (state == BUSY && in_fire && out_fire)
              || (state == FULL && out_fire);
    skid_en = state == BUSY && in_fire && !out_fire;
    main_d  = state == FULL ? skid_q : in_data;
    state_nx = state;
    case (state)
      EMPTY:   state_nx = in_fire ? BUSY : EMPTY;
      BUSY:    state_nx = in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : BUSY;
      FULL:    state_nx = out_fire ? BUSY : FULL;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end
  regn_en #(.n(n)) u_main (.clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(out_data));
  regn_en #(.n(n)) u_skid (.clk(clk), .rst(rst), .en(skid_en), .d(in_data), .q(skid_q));
endmodule
